// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU-side initiator and mem_responder.
// master = CPU side, slave = memory side.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_signed;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, req_signed,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, req_signed,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Byte/half/word load-store responder over a word-organised array; sub-word stores are RMW.
// Optional MEM_RESP_ALIGN_CHECK_EN flags misaligned/reserved-size accesses via rsp_err.
module mem_responder #(
    parameter int unsigned ADDR_W = 8
) (
    input logic           clk,
    input logic           reset,
    mem_responder_if.slave mem_io
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StRsp  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q, signed_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rword_q;
    logic [31:0]       wword;
    logic [31:0]       load_data;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic              req_err;
    logic              hs;

    logic [31:0] mem [2**ADDR_W];

    assign hs = mem_io.req_valid && (state_q == StIdle);

`ifdef MEM_RESP_ALIGN_CHECK_EN
    always_comb begin
        req_err = 1'b0;
        case (mem_io.req_size)
            2'b01:   req_err = mem_io.req_addr[0];
            2'b10:   req_err = (mem_io.req_addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end
`else
    assign req_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (hs) state_d = req_err ? StRsp : StRd;
            StRd:    state_d = we_q ? StWr : StRsp;
            StWr:    state_d = StRsp;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                we_q     <= mem_io.req_we;
                signed_q <= mem_io.req_signed;
                err_q    <= req_err;
                size_q   <= mem_io.req_size;
                addr_q   <= mem_io.req_addr[ADDR_W+1:0];
                wdata_q  <= mem_io.req_wdata;
            end
        end
    end

    // Array has no reset; an async reset drops state_q out of RD/WR before the edge.
    always_ff @(posedge clk) begin
        if (state_q == StRd) rword_q <= mem[addr_q[ADDR_W+1:2]];
        if (state_q == StWr) mem[addr_q[ADDR_W+1:2]] <= wword;
    end

    always_comb begin
        wword = rword_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    wword[7:0]   = wdata_q[7:0];
                2'd1:    wword[15:8]  = wdata_q[7:0];
                2'd2:    wword[23:16] = wdata_q[7:0];
                default: wword[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) wword[31:16] = wdata_q[15:0];
            else           wword[15:0]  = wdata_q[15:0];
        end else begin
            wword = wdata_q;
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = rword_q[7:0];
            2'd1:    lane_b = rword_q[15:8];
            2'd2:    lane_b = rword_q[23:16];
            default: lane_b = rword_q[31:24];
        endcase
        lane_h = addr_q[1] ? rword_q[31:16] : rword_q[15:0];
        if (size_q == 2'b00)      load_data = {{24{signed_q & lane_b[7]}}, lane_b};
        else if (size_q == 2'b01) load_data = {{16{signed_q & lane_h[15]}}, lane_h};
        else                      load_data = rword_q;
    end

    assign mem_io.req_ready = (state_q == StIdle);
    assign mem_io.rsp_valid = (state_q == StRsp);
    assign mem_io.rsp_err   = (state_q == StRsp) && err_q;
    assign mem_io.rsp_rdata = ((state_q == StRsp) && !we_q && !err_q) ? load_data : 32'd0;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic vs a byte model.
module tb_mem_responder;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MEM_BYTES = 4 << ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .mem_io(bus));

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mb [MEM_BYTES];

    function automatic int unsigned nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic int unsigned base_of(input logic [1:0] size, input logic [31:0] addr);
        int unsigned a;
        a = addr % MEM_BYTES;
        return a - (a % nbytes(size));
    endfunction

    function automatic logic err_of(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        return (size == 2'd3) || ((addr % nbytes(size)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        int unsigned b;
        b = base_of(size, addr);
        for (int i = 0; i < int'(nbytes(size)); i++) mb[b + i] = wdata[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                               input logic sgn);
        logic [31:0] v;
        int unsigned b, n;
        b = base_of(size, addr);
        n = nbytes(size);
        v = 32'd0;
        for (int i = 0; i < int'(n); i++) v = v | (32'(mb[b + i]) << (8 * i));
        if (sgn && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    // One request; lat is the cycle (handshake = 0) of rsp_valid, 0 if none within 10 cycles.
    task automatic xact(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic sgn,
                        output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_signed = sgn;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_signed = 1'($urandom);
        lat = 0;
        rdata = 32'd0;
        err = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = c;
                rdata = bus.rsp_rdata;
                err = bus.rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_signed = 1'b0;
        #2;
        n_cmp += 4;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata); end
        if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.rsp_err); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_preload;
        int lat; logic [31:0] rd; logic er, wd;
        for (int w = 0; w < (1 << ADDR_W); w++) begin
            wd = $urandom;
            xact(1'b1, 2'd2, 32'(w * 4), wd, 1'b0, lat, rd, er);
            model_store(2'd2, 32'(w * 4), wd);
            n_cmp++;
            if (lat != 3) begin n_bad++; $display("FAIL preload_lat w%0d: got %0d want 3", w, lat); end
        end
    endtask

    task automatic test_word_roundtrip;
        int lat; logic [31:0] rd; logic er;
        xact(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, lat, rd, er);
        model_store(2'd2, 32'h10, 32'hDEADBEEF);
        n_cmp++;
        if (lat != 3) begin n_bad++; $display("FAIL sw_lat: got %0d want 3", lat); end
        xact(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, lat, rd, er);
        n_cmp += 2;
        if (lat != 2) begin n_bad++; $display("FAIL lw_lat: got %0d want 2", lat); end
        if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_merge;
        int lat; logic [31:0] rd; logic er;
        xact(1'b1, 2'd2, 32'h20, 32'h11223344, 1'b0, lat, rd, er);
        xact(1'b1, 2'd0, 32'h22, 32'h555555AA, 1'b0, lat, rd, er);
        model_store(2'd2, 32'h20, 32'h11AA3344);
        xact(1'b0, 2'd2, 32'h20, 32'h0, 1'b0, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h11AA3344) begin n_bad++; $display("FAIL sb_merge: got %h want 11aa3344", rd); end
        xact(1'b0, 2'd0, 32'h22, 32'h0, 1'b1, lat, rd, er);
        n_cmp++;
        if (rd !== 32'hFFFFFFAA) begin n_bad++; $display("FAIL lb_signed: got %h want ffffffaa", rd); end
        xact(1'b0, 2'd0, 32'h22, 32'h0, 1'b0, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h000000AA) begin n_bad++; $display("FAIL lb_unsigned: got %h want 000000aa", rd); end
    endtask

    task automatic test_half_lanes;
        int lat; logic [31:0] rd; logic er;
        xact(1'b1, 2'd2, 32'h30, 32'h0, 1'b0, lat, rd, er);
        xact(1'b1, 2'd1, 32'h32, 32'h12348001, 1'b0, lat, rd, er);
        model_store(2'd2, 32'h30, 32'h80010000);
        xact(1'b0, 2'd2, 32'h30, 32'h0, 1'b0, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h80010000) begin n_bad++; $display("FAIL sh_merge: got %h want 80010000", rd); end
        xact(1'b0, 2'd1, 32'h32, 32'h0, 1'b1, lat, rd, er);
        n_cmp++;
        if (rd !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_signed: got %h want ffff8001", rd); end
        xact(1'b0, 2'd1, 32'h32, 32'h0, 1'b0, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h00008001) begin n_bad++; $display("FAIL lh_unsigned: got %h want 00008001", rd); end
    endtask

    // req_valid held across two IDLE windows: captures at cycles 0 and 3 only.
    task automatic test_handshake;
        logic [6:1] exp_rdy;
        logic [6:1] exp_rv;
        exp_rdy = 6'b100100;
        exp_rv  = 6'b010010;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h0; bus.req_signed = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) bus.req_valid = 1'b0;
            @(negedge clk);
            n_cmp += 2;
            if (bus.req_ready !== exp_rdy[c]) begin
                n_bad++; $display("FAIL hs_ready c%0d: got %b want %b", c, bus.req_ready, exp_rdy[c]);
            end
            if (bus.rsp_valid !== exp_rv[c]) begin
                n_bad++; $display("FAIL hs_valid c%0d: got %b want %b", c, bus.rsp_valid, exp_rv[c]);
            end
            if (exp_rv[c]) begin
                n_cmp++;
                if (bus.rsp_rdata !== model_load(2'd2, 32'h10, 1'b0)) begin
                    n_bad++; $display("FAIL hs_data c%0d: got %h want %h", c, bus.rsp_rdata,
                                      model_load(2'd2, 32'h10, 1'b0));
                end
            end
        end
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] rd; logic er;
        xact(1'b1, 2'd2, 32'h400, 32'h5A5AA5A5, 1'b0, lat, rd, er);
        model_store(2'd2, 32'h400, 32'h5A5AA5A5);
        xact(1'b0, 2'd2, 32'h000, 32'h0, 1'b0, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h5A5AA5A5) begin n_bad++; $display("FAIL wrap: got %h want 5a5aa5a5", rd); end
    endtask

    task automatic test_reset_mid_store;
        int lat; logic [31:0] rd; logic er;
        xact(1'b1, 2'd2, 32'h40, 32'h12345678, 1'b0, lat, rd, er);
        model_store(2'd2, 32'h40, 32'h12345678);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_addr = 32'h40; bus.req_wdata = 32'hCAFEF00D; bus.req_signed = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_cmp += 4;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", bus.req_ready); end
        if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL midrst_rdata: got %h want 0", bus.rsp_rdata); end
        if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", bus.rsp_err); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        xact(1'b0, 2'd2, 32'h40, 32'h0, 1'b0, lat, rd, er);
        n_cmp += 2;
        if (lat != 2) begin n_bad++; $display("FAIL midrst_lw_lat: got %0d want 2", lat); end
        if (rd !== 32'h12345678) begin n_bad++; $display("FAIL midrst_lw: got %h want 12345678", rd); end
    endtask

    task automatic test_misalign;
        int lat; logic [31:0] rd; logic er;
`ifdef MEM_RESP_ALIGN_CHECK_EN
        xact(1'b0, 2'd2, 32'h41, 32'h0, 1'b0, lat, rd, er);
        n_cmp += 3;
        if (lat != 1) begin n_bad++; $display("FAIL mis_lat: got %0d want 1", lat); end
        if (er !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", er); end
        if (rd !== 32'd0) begin n_bad++; $display("FAIL mis_rdata: got %h want 0", rd); end
        xact(1'b1, 2'd2, 32'h42, 32'hFFFFFFFF, 1'b0, lat, rd, er);
        n_cmp += 2;
        if (lat != 1) begin n_bad++; $display("FAIL mis_sw_lat: got %0d want 1", lat); end
        if (er !== 1'b1) begin n_bad++; $display("FAIL mis_sw_err: got %b want 1", er); end
        xact(1'b0, 2'd2, 32'h40, 32'h0, 1'b0, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h12345678) begin n_bad++; $display("FAIL mis_unchanged: got %h want 12345678", rd); end
`else
        xact(1'b0, 2'd2, 32'h41, 32'h0, 1'b0, lat, rd, er);
        n_cmp += 3;
        if (lat != 2) begin n_bad++; $display("FAIL mis_lat: got %0d want 2", lat); end
        if (er !== 1'b0) begin n_bad++; $display("FAIL mis_err: got %b want 0", er); end
        if (rd !== 32'h12345678) begin n_bad++; $display("FAIL mis_rdata: got %h want 12345678", rd); end
`endif
    endtask

    task automatic test_random;
        int lat; logic [31:0] rd, addr, wd, exp_rd; logic er, we, sg, exp_er; logic [1:0] sz;
        int exp_lat;
        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom);
            addr = $urandom; wd = $urandom;
            exp_er = err_of(sz, addr);
            exp_lat = exp_er ? 1 : (we ? 3 : 2);
            exp_rd = (exp_er || we) ? 32'd0 : model_load(sz, addr, sg);
            xact(we, sz, addr, wd, sg, lat, rd, er);
            if (!exp_er && we) model_store(sz, addr, wd);
            n_cmp += 3;
            if (lat != exp_lat) begin
                n_bad++; $display("FAIL rnd_lat #%0d: got %0d want %0d", k, lat, exp_lat);
            end
            if (er !== exp_er) begin
                n_bad++; $display("FAIL rnd_err #%0d: got %b want %b", k, er, exp_er);
            end
            if (rd !== exp_rd) begin
                n_bad++; $display("FAIL rnd_data #%0d we%b sz%0d a%h: got %h want %h",
                                  k, we, sz, addr, rd, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_word_roundtrip();
        test_byte_merge();
        test_half_lanes();
        test_handshake();
        test_wrap();
        test_reset_mid_store();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle CPU's load/store path. It accepts one byte, halfword or word access per handshake from the CPU-side initiator and owns a word-organised storage array. Sub-word stores are performed as an internal read-modify-write. Sub-word loads are lane-selected and sign- or zero-extended before return. It sits between the control unit / datapath and storage, and replaces direct word-only memory access for `lb/lh/lw/sb/sh/sw`.

## Interface
- `ADDR_W`, default 8: word-index width; the array holds 2^ADDR_W 32-bit words.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  size code: 00 byte, 01 half, 10 word, 11 reserved.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  access error; see Configuration.

## Operation
- States: IDLE, RD, WR, RSP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid & req_ready`, capture we, size, addr, wdata and signed, then go to RD.
- **RD**
  - Synchronous array read of word `addr[ADDR_W+1:2]` into an internal register.
  - Go to WR if we = 1, else to RSP.
- **WR**
  - Write the merged word, then go to RSP.
  - Byte store: replace lane `addr[1:0]` (lane 0 = bits [7:0], little-endian).
  - Half store: replace bits `[16*addr[1]+15 : 16*addr[1]]`.
  - Word store: replace the whole word.
  - Unselected lanes keep their old value.
- **RSP**
  - `rsp_valid` = 1 for exactly one cycle, then go to IDLE.
  - Byte load: selected lane, extended per `req_signed`.
  - Half load: selected half, extended per `req_signed`.
  - Word load: the whole word; `req_signed` is ignored.
- Address bits above `ADDR_W+1` are ignored, so addresses alias (wrap) modulo 2^(ADDR_W+2) bytes.
- Requests arriving while `req_ready` = 0 are not captured; the initiator holds them until IDLE.
- `req_*` inputs are don't-care after capture.

## Timing
- Cycle 0 is the handshake cycle.
- Load: `rsp_valid` high in cycle 2; `req_ready` high again in cycle 3.
- Store: the array is written at the end of cycle 2; `rsp_valid` is high in cycle 3; `req_ready` is high again in cycle 4.
- A load issued after a store's response returns the stored data (no hazard window).
- Reset assertion takes effect immediately, independent of `clk`. Reset values:
  - state = IDLE
  - `req_ready` = 1 (IDLE decode; it reads 1 while reset is held)
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0
- Array contents are not reset.
- Reset during RD or WR aborts the access. A store is not written unless its WR edge occurred before reset asserted.
- Reset during RSP suppresses the remainder of the response.
- The first handshake is accepted on the first rising edge after reset deasserts.

## Configuration
- Macro: `MEM_RESP_ALIGN_CHECK_EN`.
- **Defined:**
  - The following are errors: half access with `addr[0]` = 1, word access with `addr[1:0]` ≠ 0, and size 11.
  - An error request goes IDLE→RSP directly, so `rsp_valid` and `rsp_err` are high in cycle 1.
  - For errors, `rsp_rdata` = 0 and the array is never written.
  - The CPU uses `rsp_err` to raise its address exception.
- **Undefined:**
  - No error checking: `rsp_err` is tied 0.
  - Half accesses ignore `addr[0]` and word accesses ignore `addr[1:0]`.
  - Size 11 is treated as word.

## Test plan
- **Word round-trip:** sw 0xDEADBEEF @0x10, then lw @0x10 → rdata 0xDEADBEEF; `rsp_valid` in cycle 3 (store) and cycle 2 (load).
- **Byte merge:** word @0x20 = 0x11223344; sb 0xAA @0x22, then lw @0x20 → 0x11AA3344. Follow with lb signed @0x22 → 0xFFFFFFAA, and lb unsigned → 0x000000AA.
- **Half lanes:** sh 0x8001 @0x32 onto 0x00000000, then lw @0x30 → 0x80010000. lh signed @0x32 → 0xFFFF8001; lh unsigned → 0x00008001.
- **Handshake/wrap:**
  - `req_valid` held high across a load → exactly one capture per IDLE cycle; `req_ready` is 0 in cycles 1–2.
  - With `ADDR_W` = 8, sw @0x400 then lw @0x000 → same data (aliasing).
- **Reset mid-store:** word @0x40 = 0x12345678, sw 0xCAFEF00D @0x40, reset asserted during cycle 1 → all outputs at reset values; after release, lw @0x40 → 0x12345678.
- **Misalignment, macro defined:** lw @0x41 → `rsp_valid` = `rsp_err` = 1 in cycle 1, rdata 0, memory unchanged. **Undefined:** the same lw returns word @0x40 with `rsp_err` = 0.
